// File: rtl/uart_pkg.sv
`default_nettype none
// ==========================================================================
// uart_pkg : shared types and helpers for the configurable UART receiver
// Rev 1.0
// ==========================================================================
package uart_pkg;

  localparam int MAX_PAYLOAD = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic                   brk;
    logic                   ferr;
    logic                   perr;
    logic [MAX_PAYLOAD-1:0] data;
  } rx_word_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ==========================================================================
// uart_rx_fifo : first-word-fall-through FIFO of received UART words
// Rev 1.0
// ==========================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [$bits(rx_word_t)-1:0] push_word,
  input  logic                        pop,
  output logic [$bits(rx_word_t)-1:0] head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rx_word_t           mem_q [DEPTH];
  rx_word_t           mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = rx_word_t'(push_word);
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ==========================================================================
// uart_rx_cfg : oversampling UART receiver with parity, break and output FIFO
// Rev 1.0
// ==========================================================================
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         uart_rxd,
  input  logic                         uart_rx_en,
  input  logic [DIV_W-1:0]             baud_div,
  output logic [PAYLOAD_BITS-1:0]      rx_data,
  output logic                         rx_parity_err,
  output logic                         rx_frame_err,
  output logic                         rx_break,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]  rx_count
);

  localparam int              OS_W      = $clog2(OVERSAMPLE);
  localparam int              BIT_W     = 4;
  localparam logic [OS_W-1:0] SAMP_A    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SAMP_B    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SAMP_C    = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic PAR_EN   = (PARITY != int'(PAR_NONE));
  localparam logic PAR_ODDM = (PARITY == int'(PAR_ODD));

  rx_state_e                state_q, state_d;
  logic                     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]          os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic                     samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic [PAYLOAD_BITS-1:0]  shift_q, shift_d;
  logic                     pbit_q, pbit_d, ferr_q, ferr_d;
  logic                     overrun_q, overrun_d;

  logic                     rxd_s, tick, mid_tick, end_tick, bit_val;
  logic                     ferr_now, perr_now, brk_now, push, pop;
  logic                     fifo_full, fifo_empty, head_unused;
  rx_word_t                 push_word, head_word;
  logic [$bits(rx_word_t)-1:0] head_vec;

  assign rxd_s    = sync2_q;
  assign tick     = (div_cnt_q == baud_div);
  assign mid_tick = tick && (os_cnt_q == SAMP_C);
  assign end_tick = tick && (os_cnt_q == OS_LAST);
  assign bit_val  = maj3(samp_a_q, samp_b_q, rxd_s);

  assign ferr_now = ferr_q | ~bit_val;
  assign perr_now = PAR_EN && ((^shift_q ^ pbit_q) != PAR_ODDM);
  assign brk_now  = ferr_now && (shift_q == '0) && (!PAR_EN || !pbit_q);

  always_comb begin
    push_word      = '0;
    push_word.brk  = brk_now;
    push_word.ferr = ferr_now;
    push_word.perr = perr_now;
    push_word.data = MAX_PAYLOAD'(shift_q);
  end

  always_comb begin
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    if (uart_rx_en) begin
      sync1_d = uart_rxd;
      sync2_d = sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    samp_a_d  = samp_a_q;
    samp_b_d  = samp_b_q;
    shift_d   = shift_q;
    pbit_d    = pbit_q;
    ferr_d    = ferr_q;
    push      = 1'b0;

    // Counters sit at zero while idle, so every frame starts bit-aligned.
    if (state_q == IDLE || state_q == BRK_WAIT) begin
      div_cnt_d = '0;
      os_cnt_d  = '0;
    end else if (tick) begin
      div_cnt_d = '0;
      os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
    if (tick && os_cnt_q == SAMP_A) samp_a_d = rxd_s;
    if (tick && os_cnt_q == SAMP_B) samp_b_d = rxd_s;

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d   = START;
          bit_cnt_d = '0;
          ferr_d    = 1'b0;
        end
      end
      START: begin
        if (mid_tick && bit_val) state_d = IDLE;
        else if (end_tick)       state_d = DATA;
      end
      DATA: begin
        if (mid_tick) shift_d = {bit_val, shift_q[PAYLOAD_BITS-1:1]};
        if (end_tick) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (PAR_EN) state_d = uart_pkg::PARITY;
            else        state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (mid_tick) pbit_d  = bit_val;
        if (end_tick) state_d = STOP;
      end
      STOP: begin
        // Leave at mid last stop bit so a back-to-back start edge is not missed.
        if (mid_tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            push = 1'b1;
            if (brk_now) state_d = BRK_WAIT;
            else         state_d = IDLE;
          end else begin
            ferr_d = ferr_now;
          end
        end
        if (end_tick) bit_cnt_d = bit_cnt_q + 1'b1;
      end
      BRK_WAIT: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!uart_rx_en) begin
      state_d = IDLE;
      push    = 1'b0;
    end
    overrun_d = push && fifo_full && !pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      samp_a_q  <= 1'b0;
      samp_b_q  <= 1'b0;
      shift_q   <= '0;
      pbit_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      samp_a_q  <= samp_a_d;
      samp_b_q  <= samp_b_d;
      shift_q   <= shift_d;
      pbit_q    <= pbit_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign pop = rx_valid && rx_ready;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head_vec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rx_count)
  );

  assign head_word     = rx_word_t'(head_vec);
  assign head_unused   = ^head_word.data;
  assign rx_data       = head_word.data[PAYLOAD_BITS-1:0];
  assign rx_parity_err = head_word.perr;
  assign rx_frame_err  = head_word.ferr;
  assign rx_break      = head_word.brk;
  assign rx_valid      = !fifo_empty;
  assign rx_overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ==========================================================================
// tb_uart_rx_cfg : vector table plus scoreboard for 8N1 and 8E1 receivers
// Rev 1.0
// ==========================================================================
module tb_uart_rx_cfg;

  localparam int BIT_CLK = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        rxd0 = 1'b1, rxd1 = 1'b1;
  logic        ready0 = 1'b1, ready1 = 1'b1;

  logic [7:0]  data0, data1;
  logic        perr0, ferr0, brk0, valid0, ovr0;
  logic        perr1, ferr1, brk1, valid1, ovr1;
  logic [2:0]  count0, count1;

  always #5 clk = ~clk;

  uart_rx_cfg dut (
    .clk(clk), .reset(reset), .uart_rxd(rxd0), .uart_rx_en(en), .baud_div(baud_div),
    .rx_data(data0), .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_break(brk0),
    .rx_valid(valid0), .rx_ready(ready0), .rx_overrun(ovr0), .rx_count(count0)
  );

  uart_rx_cfg #(.PARITY(1)) dut_par (
    .clk(clk), .reset(reset), .uart_rxd(rxd1), .uart_rx_en(en), .baud_div(baud_div),
    .rx_data(data1), .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_break(brk1),
    .rx_valid(valid1), .rx_ready(ready1), .rx_overrun(ovr1), .rx_count(count1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int valid_cyc0 = 0;
  int rise_cyc0 = 0;
  int ovr_pulses0 = 0;
  logic prev_valid0 = 1'b0;
  // word layout: {dut select, brk, ferr, perr, data}
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid0 && ready0) obs_q.push_back({1'b0, brk0, ferr0, perr0, data0});
    if (valid1 && ready1) obs_q.push_back({1'b1, brk1, ferr1, perr1, data1});
    if (valid0) valid_cyc0++;
    if (valid0 && !prev_valid0) rise_cyc0 = cyc;
    prev_valid0 = valid0;
    if (ovr0) ovr_pulses0++;
  end

  typedef struct packed {
    logic       sel;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [2:0] flags;   // {brk, ferr, perr}
  } vec_t;

  vec_t vecs[12];

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic sel, input logic b);
    if (sel) rxd1 = b;
    else     rxd0 = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] d, input logic pbit,
                            input logic stop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (sel) send_bit(sel, pbit);
    stop_cyc = cyc;
    send_bit(sel, stop);
    send_bit(sel, 1'b1);
  endtask

  task automatic score(input string name);
    logic [11:0] e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) a = obs_q.pop_front();
      else                  a = 'x;
      check(name, {20'd0, a}, {20'd0, e});
    end
    check({name, "_extra"}, obs_q.size(), 0);
  endtask

  initial begin
    int v_snap, o_snap;

    vecs[0]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 3'b000};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'b000};
    vecs[2]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 3'b000};
    vecs[3]  = '{1'b0, 8'h3C, 1'b0, 1'b1, 3'b000};
    vecs[4]  = '{1'b0, 8'h81, 1'b0, 1'b0, 3'b010};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'b110};
    vecs[6]  = '{1'b1, 8'h07, 1'b0, 1'b1, 3'b001};
    vecs[7]  = '{1'b1, 8'h07, 1'b1, 1'b1, 3'b000};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'b011};
    vecs[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'b110};
    vecs[10] = '{1'b1, 8'h5A, 1'b0, 1'b1, 3'b000};
    vecs[11] = '{1'b1, 8'h01, 1'b1, 1'b1, 3'b000};

    wait_clk(3);
    check("reset_outputs",
          {16'd0, valid0, count0, ovr0, brk0, ferr0, perr0, data0}, 32'd0);
    reset = 1'b0;
    wait_clk(4);

    // 0xA5: one-cycle valid, push around mid stop bit
    v_snap = valid_cyc0;
    exp_q.push_back({1'b0, 3'b000, 8'hA5});
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    score("a5_word");
    check("a5_valid_cycles", valid_cyc0 - v_snap, 1);
    check("a5_push_time",
          {31'd0, (rise_cyc0 - stop_cyc >= 30) && (rise_cyc0 - stop_cyc <= 56)}, 1);

    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({vecs[i].sel, vecs[i].flags, vecs[i].data});
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].pbit, vecs[i].stop);
      score($sformatf("vec%0d", i));
    end

    // long break: exactly one break word
    exp_q.push_back({1'b0, 3'b110, 8'h00});
    rxd0 = 1'b0;
    wait_clk(12 * BIT_CLK);
    rxd0 = 1'b1;
    wait_clk(3 * BIT_CLK);
    score("break");
    exp_q.push_back({1'b0, 3'b000, 8'h42});
    send_frame(1'b0, 8'h42, 1'b0, 1'b1);
    score("after_break");

    // glitch on idle line
    v_snap = valid_cyc0;
    rxd0 = 1'b0;
    wait_clk(2);
    rxd0 = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("glitch_no_word", {count0, 29'd0} | (valid_cyc0 - v_snap), 0);
    exp_q.push_back({1'b0, 3'b000, 8'h96});
    send_frame(1'b0, 8'h96, 1'b0, 1'b1);
    score("after_glitch");

    // overrun: six frames into a four-deep FIFO with no consumer
    ready0 = 1'b0;
    o_snap = ovr_pulses0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) exp_q.push_back({1'b0, 3'b000, 8'(i)});
      send_frame(1'b0, 8'(i), 1'b0, 1'b1);
    end
    check("ovr_count", count0, 4);
    check("ovr_pulses", ovr_pulses0 - o_snap, 2);
    ready0 = 1'b1;
    wait_clk(10);
    score("ovr_order");
    check("ovr_drained", count0, 0);

    // receive enable dropped during data bit 3
    v_snap = valid_cyc0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'(8'h3C >> i));
    rxd0 = 1'b1;
    wait_clk(32);
    en = 1'b0;
    wait_clk(100);
    en = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("en_drop_no_word", {count0, 29'd0} | (valid_cyc0 - v_snap), 0);
    score("en_drop");
    exp_q.push_back({1'b0, 3'b000, 8'h3C});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    score("after_en_drop");

    // reset mid-frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    rxd0 = 1'b1;
    reset = 1'b1;
    wait_clk(3);
    check("rst_mid_state", {count0, valid0}, 0);
    reset = 1'b0;
    wait_clk(2 * BIT_CLK);
    score("rst_mid");
    exp_q.push_back({1'b0, 3'b000, 8'hC3});
    send_frame(1'b0, 8'hC3, 1'b0, 1'b1);
    score("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
